// File: rtl/mips32_pkg.sv
// Shared MIPS32 opcode constants and instruction-field helpers for the core front end.
package mips32_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OP_HLT   = 6'h3f;
  localparam logic [5:0] OP_BEQZ  = 6'h0e;
  localparam logic [5:0] OP_BNEQZ = 6'h0d;

  function automatic logic [5:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-6];
  endfunction

endpackage

// File: rtl/mips32_fetch_unit_fifo.sv
// Synchronous FIFO with flush and occupancy count; used for the instruction queue and the
// in-flight address-tag queue of the fetch unit. DEPTH need not be a power of two.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // A push into a full queue is accepted when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ((count != CW'(DEPTH)) | do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mips32_fetch_unit.sv
// MIPS32 instruction fetch front end: credit-limited imem reads, in-order response queue,
// redirect flush and HLT stop. Define FETCH_STATS_EN to add fetch/flush statistic counters.
module mips32_fetch_unit
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_npc,
  output logic        fetch_halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTST + 1);

  logic [31:0]  pc;
  logic [OCW-1:0] drop;
  logic         halt_seen;
  logic [QCW-1:0] q_count;
  logic [OCW-1:0] outst;
  logic [63:0]  q_rdata;
  logic [31:0]  tag_addr;
  logic         req_fire;
  logic         rsp_discard;
  logic         q_push;
  logic         q_pop;
  logic         hlt_push;

  // Reads are gated by rst_n so the request line is quiet while reset is held.
  always_comb begin
    imem_req_valid = rst_n & fetch_en & ~halt_seen & ~redir_valid
                   & (32'(outst) < MAX_OUTST)
                   & (32'(q_count) + 32'(outst) < DEPTH);
    req_fire    = imem_req_valid & imem_req_ready;
    rsp_discard = redir_valid | (drop != '0) | halt_seen;
    q_push      = imem_rsp_valid & ~rsp_discard;
    q_pop       = id_valid & id_ready & ~redir_valid;
    hlt_push    = q_push & (opcode(imem_rsp_data) == OP_HLT);
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .wdata ({imem_rsp_data, tag_addr + 32'd1}),
    .pop   (q_pop),
    .flush (redir_valid),
    .rdata (q_rdata),
    .count (q_count)
  );

  // Tags track every issued read, including ones later discarded, so occupancy equals outst.
  fetch_fifo #(.DEPTH(MAX_OUTST), .WIDTH(32)) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .wdata (pc),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .rdata (tag_addr),
    .count (outst)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      drop      <= '0;
      halt_seen <= 1'b0;
    end else if (redir_valid) begin
      pc        <= redir_pc;
      halt_seen <= 1'b0;
      drop      <= outst - OCW'(imem_rsp_valid);
    end else begin
      if (req_fire)                      pc <= pc + 32'd1;
      if (imem_rsp_valid && drop != '0)  drop <= drop - 1'b1;
      if (hlt_push)                      halt_seen <= 1'b1;
    end
  end

  always_comb begin
    id_valid      = (q_count != '0);
    id_instr      = id_valid ? q_rdata[63:32] : '0;
    id_npc        = id_valid ? q_rdata[31:0]  : '0;
    imem_req_addr = pc;
    fetch_halted  = halt_seen;
  end

`ifdef FETCH_STATS_EN
  // A redirect accounts for all in-flight reads up front; later drop-counted ones are not recounted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (q_push) stat_fetched <= stat_fetched + 32'd1;
      if (redir_valid)
        stat_flushed <= stat_flushed + 32'(q_count) + 32'(outst);
      else if (imem_rsp_valid && drop == '0 && halt_seen)
        stat_flushed <= stat_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// Self-checking bench for mips32_fetch_unit: behavioural queue model plus directed scenarios.
module tb_mips32_fetch_unit;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'd0;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_npc;
  logic        fetch_halted;

  mips32_fetch_unit #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_npc         (id_npc),
    .fetch_halted   (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] npc; } ent_t;
  typedef struct { logic [31:0] addr; bit live; } fl_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  int n_reads = 0;
  logic [31:0] max_rd = 0;

  logic [31:0] mem [256];
  logic [31:0] prog [8];
  pend_t pend[$];
  ent_t  dlog[$];

  ent_t  mq[$];
  fl_t   mf[$];
  logic [31:0] m_pc;
  bit    m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_env();
    mq.delete(); mf.delete(); pend.delete(); dlog.delete();
    m_pc = RESET_PC; m_halt = 0; n_reads = 0; max_rd = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 0);
    chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    chk({tag, "_id_valid"}, 32'(id_valid), 0);
    chk({tag, "_id_instr"}, id_instr, 0);
    chk({tag, "_id_npc"}, id_npc, 0);
    chk({tag, "_halted"}, 32'(fetch_halted), 0);
  endtask

  task automatic do_reset(input int latency);
    rst_n = 1'b0; fetch_en = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0; imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    clear_env();
    lat = latency;
    rst_n = 1'b1;
  endtask

  task automatic cyc_begin();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem[pend[0].addr[7:0]];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic cyc_end();
    bit exp_rv;
    bit hlt_now;
    fl_t f;
    #1;
    exp_rv = fetch_en && !m_halt && !redir_valid && (mf.size() < MAX_OUTST)
             && (mq.size() + mf.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("id_instr", id_instr, mq[0].instr);
      chk("id_npc", id_npc, mq[0].npc);
    end
    chk("fetch_halted", 32'(fetch_halted), 32'(m_halt));

    if (id_valid && id_ready && !redir_valid) dlog.push_back(ent_t'{id_instr, id_npc});
    if (imem_req_valid && imem_req_ready) begin
      pend.push_back(pend_t'{imem_req_addr, cyc + lat});
      n_reads++;
      if (imem_req_addr > max_rd) max_rd = imem_req_addr;
    end
    if (imem_rsp_valid) void'(pend.pop_front());

    // Model: in-flight reads carry a live flag; a flush kills them instead of counting.
    hlt_now = 0;
    f = fl_t'{32'd0, 1'b0};
    if (imem_rsp_valid && mf.size() > 0) f = mf.pop_front();
    if (redir_valid) begin
      mq.delete();
      for (int i = 0; i < mf.size(); i++) mf[i].live = 0;
      m_pc = redir_pc;
      m_halt = 0;
    end else begin
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (imem_rsp_valid && f.live) begin
        mq.push_back(ent_t'{mem[f.addr[7:0]], f.addr + 32'd1});
        if (mem[f.addr[7:0]][31:26] == 6'h3f) hlt_now = 1;
      end
      if (exp_rv && imem_req_ready) begin
        mf.push_back(fl_t'{m_pc, 1'b1});
        m_pc = m_pc + 32'd1;
      end
      if (hlt_now) begin
        for (int i = 0; i < mf.size(); i++) mf[i].live = 0;
        m_halt = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      cyc_end();
    end
  endtask

  task automatic check_program(input string tag);
    chk({tag, "_count"}, 32'(dlog.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < dlog.size()) begin
        chk({tag, "_instr"}, dlog[i].instr, prog[i]);
        chk({tag, "_npc"}, dlog[i].npc, 32'(i + 1));
      end
    end
  endtask

  initial begin
    int base;
    bit found;
    prog[0] = 32'h28010078; prog[1] = 32'h0c631800; prog[2] = 32'h20220000;
    prog[3] = 32'h0c631800; prog[4] = 32'h2842002d; prog[5] = 32'h0c631800;
    prog[6] = 32'h24220001; prog[7] = 32'hfc000000;
    for (int i = 0; i < 256; i++) mem[i] = 32'h04000000 | 32'(i);
    for (int i = 0; i < 8; i++) mem[i] = prog[i];

    // 1: straight-line program, latency 1, decode always ready
    do_reset(1);
    fetch_en = 1'b1; id_ready = 1'b1;
    run(24);
    check_program("t1");
    chk("t1_halted", 32'(fetch_halted), 1);
    chk("t1_max_read", max_rd, 8);

    // 2: decode stalled, queue fills to DEPTH, then drains in order
    do_reset(1);
    fetch_en = 1'b1; id_ready = 1'b0;
    run(12);
    chk("t2_reads_stalled", 32'(n_reads), DEPTH);
    chk("t2_delivered_stalled", 32'(dlog.size()), 0);
    chk("t2_id_valid", 32'(id_valid), 1);
    chk("t2_req_valid", 32'(imem_req_valid), 0);
    id_ready = 1'b1;
    run(24);
    check_program("t2");

    // 3: latency 3, redirect to 120 with two reads in flight
    do_reset(3);
    fetch_en = 1'b1; id_ready = 1'b1;
    found = 0; base = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc_begin();
      if (pend.size() == 2) begin
        redir_valid = 1'b1; redir_pc = 32'd120; base = dlog.size(); found = 1;
      end
      cyc_end();
      redir_valid = 1'b0;
    end
    chk("t3_redirect_reached", 32'(found), 1);
    run(16);
    chk("t3_delivered", 32'(dlog.size() > base), 1);
    if (dlog.size() > base) begin
      chk("t3_first_instr", dlog[base].instr, 32'h04000078);
      chk("t3_first_npc", dlog[base].npc, 32'd121);
    end

    // 4: HLT at address 2, read of 3 in flight gets discarded; redirect restarts
    do_reset(3);
    mem[2] = 32'hfc000000;
    fetch_en = 1'b1; id_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc_begin();
      cyc_end();
      found = fetch_halted;
    end
    chk("t4_halt_reached", 32'(found), 1);
    run(8);
    chk("t4_delivered", 32'(dlog.size()), 3);
    if (dlog.size() >= 3) chk("t4_hlt_instr", dlog[2].instr, 32'hfc000000);
    chk("t4_reads", 32'(n_reads), 4);
    chk("t4_still_halted", 32'(fetch_halted), 1);
    cyc_begin();
    redir_valid = 1'b1; redir_pc = 32'd0;
    cyc_end();
    redir_valid = 1'b0;
    chk("t4_halt_cleared", 32'(fetch_halted), 0);
    run(10);
    if (dlog.size() > 3) chk("t4_resume_npc", dlog[3].npc, 32'd1);
    else chk("t4_resume_count", 32'(dlog.size()), 4);
    mem[2] = prog[2];

    // 5: response, pop and redirect in one cycle
    do_reset(1);
    fetch_en = 1'b1; id_ready = 1'b1;
    found = 0; base = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc_begin();
      if (imem_rsp_valid && id_valid) begin
        redir_valid = 1'b1; redir_pc = 32'd40; base = dlog.size(); found = 1;
      end
      cyc_end();
      redir_valid = 1'b0;
    end
    chk("t5_redirect_reached", 32'(found), 1);
    chk("t5_queue_empty", 32'(id_valid), 0);
    run(10);
    if (dlog.size() > base) begin
      chk("t5_first_npc", dlog[base].npc, 32'd41);
      chk("t5_first_instr", dlog[base].instr, 32'h04000028);
    end else chk("t5_delivered", 32'(dlog.size()), 32'(base + 1));

    // 6: asynchronous reset pulse with a full queue
    do_reset(1);
    fetch_en = 1'b1; id_ready = 1'b0;
    run(10);
    chk("t6_full", 32'(n_reads), DEPTH);
    cyc_begin();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    clear_env();
    cyc++;
    rst_n = 1'b1;
    id_ready = 1'b1;
    run(24);
    check_program("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
